// File: rtl/warp_fetch_scheduler.sv
// Per-warp control-flow scheduler: tracks PC/mask/state for each warp slot,
// round-robin picks one eligible warp per fetch handshake and retires exited warps.
module warp_fetch_scheduler #(
  parameter int NumWarps  = 8,
  parameter int PcWidth   = 32,
  parameter int WarpWidth = 32,
  parameter int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [PcWidth-1:0]   launch_pc_i,
  input  logic [WarpWidth-1:0] launch_act_mask_i,
  input  logic [NumWarps-1:0]  ib_space_available_i,
  input  logic [NumWarps-1:0]  ib_all_instr_finished_i,
  output logic                 fe_valid_o,
  input  logic                 fe_ready_i,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic                 fe_handshake_o,
  input  logic                 dec_valid_i,
  input  logic [WidWidth-1:0]  dec_warp_id_i,
  input  logic [1:0]           dec_ctrl_i,
  input  logic                 bru_valid_i,
  input  logic [WidWidth-1:0]  bru_warp_id_i,
  input  logic [PcWidth-1:0]   bru_next_pc_i,
  input  logic [WarpWidth-1:0] bru_act_mask_i,
  output logic                 warp_done_o,
  output logic [WidWidth-1:0]  warp_done_id_o,
  output logic                 all_idle_o
);

  typedef enum logic [2:0] {
    ST_FREE     = 3'd0,
    ST_READY    = 3'd1,
    ST_WAIT_DEC = 3'd2,
    ST_WAIT_BR  = 3'd3,
    ST_EXITING  = 3'd4
  } warp_state_e;

  warp_state_e          state_q [NumWarps];
  warp_state_e          state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];

  logic [WidWidth-1:0]  rr_q, rr_d;
  logic                 lock_q, lock_d;
  logic [WidWidth-1:0]  lock_id_q, lock_id_d;
  logic                 done_q, done_d;
  logic [WidWidth-1:0]  done_id_q, done_id_d;

  logic [NumWarps-1:0]  eligible;
  logic [NumWarps-1:0]  free_vec;
  logic [NumWarps-1:0]  exit_vec;
  logic [WidWidth-1:0]  cand [NumWarps];
  logic                 rr_found;
  logic [WidWidth-1:0]  rr_sel;
  logic [WidWidth-1:0]  sel_id;
  logic                 fe_valid;
  logic                 handshake;
  logic                 launch_fire;
  logic [WidWidth-1:0]  launch_id;
  logic                 exit_any;
  logic [WidWidth-1:0]  exit_id;

  always_comb begin
    eligible = '0;
    free_vec = '0;
    exit_vec = '0;
    for (int w = 0; w < NumWarps; w++) begin
      eligible[w] = (state_q[w] == ST_READY) && ib_space_available_i[w];
      free_vec[w] = (state_q[w] == ST_FREE);
      exit_vec[w] = (state_q[w] == ST_EXITING) && ib_all_instr_finished_i[w];
    end
  end

  // Candidate order for round-robin: rr_q, rr_q+1, ... wrapping at NumWarps.
  always_comb begin
    for (int i = 0; i < NumWarps; i++) begin
      cand[i] = WidWidth'((int'(rr_q) + i) % NumWarps);
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int i = 0; i < NumWarps; i++) begin
      if (!rr_found && eligible[cand[i]]) begin
        rr_found = 1'b1;
        rr_sel   = cand[i];
      end
    end
  end

  always_comb begin
    launch_fire = 1'b0;
    launch_id   = '0;
    exit_any    = 1'b0;
    exit_id     = '0;
    for (int w = 0; w < NumWarps; w++) begin
      if (!launch_fire && free_vec[w]) begin
        launch_fire = 1'b1;
        launch_id   = WidWidth'(w);
      end
      if (!exit_any && exit_vec[w]) begin
        exit_any = 1'b1;
        exit_id  = WidWidth'(w);
      end
    end
    launch_fire = launch_fire && launch_valid_i;
  end

  // Valid/ready: once fe_valid_o rises it stays high with id, pc and mask
  // frozen until fe_ready_i is seen; the transfer happens on valid && ready.
  assign sel_id    = lock_q ? lock_id_q : rr_sel;
  assign fe_valid  = lock_q || rr_found;
  assign handshake = fe_valid && fe_ready_i;

  assign lock_d    = fe_valid && !fe_ready_i;
  assign lock_id_d = sel_id;
  assign done_d    = exit_any;
  assign done_id_d = exit_id;

  always_comb begin
    rr_d = rr_q;
    if (handshake) begin
      if (int'(sel_id) == NumWarps - 1) rr_d = '0;
      else                              rr_d = sel_id + WidWidth'(1);
    end
  end

  // Events for one warp are mutually exclusive because each requires a distinct state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    for (int w = 0; w < NumWarps; w++) begin
      if (launch_fire && launch_id == WidWidth'(w)) begin
        state_d[w] = ST_READY;
        pc_d[w]    = launch_pc_i;
        mask_d[w]  = launch_act_mask_i;
      end
      if (handshake && sel_id == WidWidth'(w)) begin
        state_d[w] = ST_WAIT_DEC;
        pc_d[w]    = pc_q[w] + PcWidth'(1);
      end
      if (dec_valid_i && dec_warp_id_i == WidWidth'(w) && state_q[w] == ST_WAIT_DEC) begin
        case (dec_ctrl_i)
          2'd1:    state_d[w] = ST_WAIT_BR;
          2'd2:    state_d[w] = ST_EXITING;
          default: state_d[w] = ST_READY;
        endcase
      end
      if (bru_valid_i && bru_warp_id_i == WidWidth'(w) && state_q[w] == ST_WAIT_BR) begin
        pc_d[w]    = bru_next_pc_i;
        mask_d[w]  = bru_act_mask_i;
        state_d[w] = (bru_act_mask_i == '0) ? ST_EXITING : ST_READY;
      end
      if (exit_any && exit_id == WidWidth'(w)) begin
        state_d[w] = ST_FREE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= ST_FREE;
        pc_q[w]    <= '0;
        mask_q[w]  <= '0;
      end
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mask_q    <= mask_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign launch_ready_o = |free_vec;
  assign all_idle_o     = &free_vec;
  assign fe_valid_o     = fe_valid;
  assign fe_handshake_o = handshake;
  assign fe_warp_id_o   = fe_valid ? sel_id : '0;
  assign fe_pc_o        = fe_valid ? pc_q[sel_id] : '0;
  assign fe_act_mask_o  = fe_valid ? mask_q[sel_id] : '0;
  assign warp_done_o    = done_q;
  assign warp_done_id_o = done_id_q;

`ifndef SYNTHESIS
  a_dec_in_wait_dec: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dec_valid_i |-> state_q[dec_warp_id_i] == ST_WAIT_DEC);
  a_bru_in_wait_br: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bru_valid_i |-> state_q[bru_warp_id_i] == ST_WAIT_BR);
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed self-checking bench for warp_fetch_scheduler: launch, round-robin,
// request hold, branch/exit flow, PC wrap and asynchronous reset.
module tb_warp_fetch_scheduler;
  localparam int NumWarps  = 8;
  localparam int PcWidth   = 32;
  localparam int WarpWidth = 32;
  localparam int WidWidth  = 3;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 launch_valid_i;
  logic                 launch_ready_o;
  logic [PcWidth-1:0]   launch_pc_i;
  logic [WarpWidth-1:0] launch_act_mask_i;
  logic [NumWarps-1:0]  ib_space_available_i;
  logic [NumWarps-1:0]  ib_all_instr_finished_i;
  logic                 fe_valid_o;
  logic                 fe_ready_i;
  logic [WidWidth-1:0]  fe_warp_id_o;
  logic [PcWidth-1:0]   fe_pc_o;
  logic [WarpWidth-1:0] fe_act_mask_o;
  logic                 fe_handshake_o;
  logic                 dec_valid_i;
  logic [WidWidth-1:0]  dec_warp_id_i;
  logic [1:0]           dec_ctrl_i;
  logic                 bru_valid_i;
  logic [WidWidth-1:0]  bru_warp_id_i;
  logic [PcWidth-1:0]   bru_next_pc_i;
  logic [WarpWidth-1:0] bru_act_mask_i;
  logic                 warp_done_o;
  logic [WidWidth-1:0]  warp_done_id_o;
  logic                 all_idle_o;

  int checks = 0;
  int errors = 0;

  warp_fetch_scheduler #(
    .NumWarps(NumWarps), .PcWidth(PcWidth), .WarpWidth(WarpWidth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .launch_valid_i(launch_valid_i), .launch_ready_o(launch_ready_o),
    .launch_pc_i(launch_pc_i), .launch_act_mask_i(launch_act_mask_i),
    .ib_space_available_i(ib_space_available_i),
    .ib_all_instr_finished_i(ib_all_instr_finished_i),
    .fe_valid_o(fe_valid_o), .fe_ready_i(fe_ready_i),
    .fe_warp_id_o(fe_warp_id_o), .fe_pc_o(fe_pc_o),
    .fe_act_mask_o(fe_act_mask_o), .fe_handshake_o(fe_handshake_o),
    .dec_valid_i(dec_valid_i), .dec_warp_id_i(dec_warp_id_i), .dec_ctrl_i(dec_ctrl_i),
    .bru_valid_i(bru_valid_i), .bru_warp_id_i(bru_warp_id_i),
    .bru_next_pc_i(bru_next_pc_i), .bru_act_mask_i(bru_act_mask_i),
    .warp_done_o(warp_done_o), .warp_done_id_o(warp_done_id_o),
    .all_idle_o(all_idle_o)
  );

  // Clock and reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni                  = 1'b0;
    launch_valid_i          = 1'b0;
    launch_pc_i             = '0;
    launch_act_mask_i       = '0;
    ib_space_available_i    = '1;
    ib_all_instr_finished_i = '0;
    fe_ready_i              = 1'b0;
    dec_valid_i             = 1'b0;
    dec_warp_id_i           = '0;
    dec_ctrl_i              = '0;
    bru_valid_i             = 1'b0;
    bru_warp_id_i           = '0;
    bru_next_pc_i           = '0;
    bru_act_mask_i          = '0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic launch(input logic [31:0] pc, input logic [31:0] mask);
    launch_valid_i    = 1'b1;
    launch_pc_i       = pc;
    launch_act_mask_i = mask;
    cyc();
    launch_valid_i    = 1'b0;
  endtask

  task automatic decode(input logic [2:0] id, input logic [1:0] ctrl);
    dec_valid_i   = 1'b1;
    dec_warp_id_i = id;
    dec_ctrl_i    = ctrl;
    cyc();
    dec_valid_i   = 1'b0;
  endtask

  task automatic branch(input logic [2:0] id, input logic [31:0] pc, input logic [31:0] mask);
    bru_valid_i    = 1'b1;
    bru_warp_id_i  = id;
    bru_next_pc_i  = pc;
    bru_act_mask_i = mask;
    cyc();
    bru_valid_i    = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (fe_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fe_valid got %0b exp 0", fe_valid_o); end
    checks++; if (warp_done_o !== 1'b0) begin errors++; $display("FAIL reset_warp_done got %0b exp 0", warp_done_o); end
    checks++; if (launch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_launch_ready got %0b exp 1", launch_ready_o); end
    checks++; if (all_idle_o !== 1'b1) begin errors++; $display("FAIL reset_all_idle got %0b exp 1", all_idle_o); end
    checks++; if (fe_pc_o !== 32'h0 || fe_warp_id_o !== 3'd0 || fe_act_mask_o !== 32'h0) begin
      errors++; $display("FAIL reset_fe_zero got id=%0d pc=%0h mask=%0h exp 0", fe_warp_id_o, fe_pc_o, fe_act_mask_o);
    end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    fe_ready_i = 1'b1;
    launch(32'h100, 32'hFFFF_FFFF);
    checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h100) begin
      errors++; $display("FAIL basic_first got v=%0b id=%0d pc=%0h exp v=1 id=0 pc=100", fe_valid_o, fe_warp_id_o, fe_pc_o);
    end
    checks++; if (fe_act_mask_o !== 32'hFFFF_FFFF || fe_handshake_o !== 1'b1) begin
      errors++; $display("FAIL basic_mask got mask=%0h hs=%0b exp ffffffff 1", fe_act_mask_o, fe_handshake_o);
    end
    cyc();
    checks++; if (fe_valid_o !== 1'b0 || fe_pc_o !== 32'h0) begin
      errors++; $display("FAIL basic_wait_dec got v=%0b pc=%0h exp v=0 pc=0", fe_valid_o, fe_pc_o);
    end
    decode(3'd0, 2'd0);
    checks++; if (fe_valid_o !== 1'b1 || fe_pc_o !== 32'h101) begin
      errors++; $display("FAIL basic_next_pc got v=%0b pc=%0h exp v=1 pc=101", fe_valid_o, fe_pc_o);
    end
    fe_ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    launch(32'h1000, 32'h1);
    launch(32'h2000, 32'h2);
    launch(32'h3000, 32'h4);
    fe_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'(k % 3)) begin
        errors++; $display("FAIL rr_grant_%0d got v=%0b id=%0d exp v=1 id=%0d", k, fe_valid_o, fe_warp_id_o, k % 3);
      end
      if (k > 0) begin
        dec_valid_i   = 1'b1;
        dec_warp_id_i = 3'((k - 1) % 3);
        dec_ctrl_i    = 2'd0;
      end
      cyc();
    end
    dec_valid_i = 1'b0;
    fe_ready_i  = 1'b0;
  endtask

  task automatic test_hold_request();
    do_reset();
    launch(32'h200, 32'hA5A5_A5A5);
    launch(32'h300, 32'h0F0F_0F0F);
    ib_space_available_i = 8'h02;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd0 || fe_pc_o !== 32'h200 || fe_act_mask_o !== 32'hA5A5_A5A5) begin
        errors++; $display("FAIL hold_%0d got v=%0b id=%0d pc=%0h mask=%0h exp v=1 id=0 pc=200 mask=a5a5a5a5",
                           i, fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o);
      end
      cyc();
    end
    fe_ready_i = 1'b1;
    cyc();
    checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h300 || fe_act_mask_o !== 32'h0F0F_0F0F) begin
      errors++; $display("FAIL hold_release got v=%0b id=%0d pc=%0h mask=%0h exp v=1 id=1 pc=300 mask=0f0f0f0f",
                         fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o);
    end
    fe_ready_i = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    fe_ready_i = 1'b1;
    launch(32'h500, 32'hFFFF_FFFF);
    cyc();
    decode(3'd0, 2'd1);
    checks++; if (fe_valid_o !== 1'b0) begin errors++; $display("FAIL br_wait_a got v=%0b exp 0", fe_valid_o); end
    cyc();
    checks++; if (fe_valid_o !== 1'b0) begin errors++; $display("FAIL br_wait_b got v=%0b exp 0", fe_valid_o); end
    branch(3'd0, 32'h40, 32'h0000_00FF);
    checks++; if (fe_valid_o !== 1'b1 || fe_pc_o !== 32'h40 || fe_act_mask_o !== 32'h0000_00FF) begin
      errors++; $display("FAIL br_target got v=%0b pc=%0h mask=%0h exp v=1 pc=40 mask=ff", fe_valid_o, fe_pc_o, fe_act_mask_o);
    end
    cyc();
    decode(3'd0, 2'd1);
    branch(3'd0, 32'h77, 32'h0);
    checks++; if (fe_valid_o !== 1'b0 || all_idle_o !== 1'b0 || warp_done_o !== 1'b0) begin
      errors++; $display("FAIL br_exiting got v=%0b idle=%0b done=%0b exp 0 0 0", fe_valid_o, all_idle_o, warp_done_o);
    end
    ib_all_instr_finished_i = '1;
    cyc();
    checks++; if (warp_done_o !== 1'b1 || warp_done_id_o !== 3'd0 || all_idle_o !== 1'b1) begin
      errors++; $display("FAIL br_done got done=%0b id=%0d idle=%0b exp 1 0 1", warp_done_o, warp_done_id_o, all_idle_o);
    end
    ib_all_instr_finished_i = '0;
    fe_ready_i = 1'b0;
  endtask

  task automatic test_exit_reuse();
    do_reset();
    fe_ready_i = 1'b1;
    ib_space_available_i = 8'h08;
    for (int i = 0; i < 8; i++) begin
      launch(32'h10 + 32'(i), 32'h1 << i);
      if (i == 3) begin
        checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd3 || fe_pc_o !== 32'h13) begin
          errors++; $display("FAIL exit_fetch got v=%0b id=%0d pc=%0h exp v=1 id=3 pc=13", fe_valid_o, fe_warp_id_o, fe_pc_o);
        end
      end
    end
    checks++; if (launch_ready_o !== 1'b0 || fe_valid_o !== 1'b0) begin
      errors++; $display("FAIL exit_full got lr=%0b v=%0b exp 0 0", launch_ready_o, fe_valid_o);
    end
    decode(3'd3, 2'd2);
    for (int i = 0; i < 5; i++) begin
      checks++; if (warp_done_o !== 1'b0 || launch_ready_o !== 1'b0) begin
        errors++; $display("FAIL exit_drain_%0d got done=%0b lr=%0b exp 0 0", i, warp_done_o, launch_ready_o);
      end
      cyc();
    end
    ib_all_instr_finished_i = 8'h08;
    cyc();
    ib_all_instr_finished_i = '0;
    checks++; if (warp_done_o !== 1'b1 || warp_done_id_o !== 3'd3 || launch_ready_o !== 1'b1) begin
      errors++; $display("FAIL exit_done got done=%0b id=%0d lr=%0b exp 1 3 1", warp_done_o, warp_done_id_o, launch_ready_o);
    end
    launch(32'h999, 32'h3);
    checks++; if (warp_done_o !== 1'b0 || launch_ready_o !== 1'b0) begin
      errors++; $display("FAIL exit_pulse got done=%0b lr=%0b exp 0 0", warp_done_o, launch_ready_o);
    end
    checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd3 || fe_pc_o !== 32'h999 || fe_act_mask_o !== 32'h3) begin
      errors++; $display("FAIL exit_reuse got v=%0b id=%0d pc=%0h mask=%0h exp v=1 id=3 pc=999 mask=3",
                         fe_valid_o, fe_warp_id_o, fe_pc_o, fe_act_mask_o);
    end
    fe_ready_i = 1'b0;
  endtask

  task automatic test_multi_exit();
    do_reset();
    fe_ready_i = 1'b1;
    launch(32'h700, 32'h1);
    launch(32'h800, 32'h2);
    checks++; if (fe_valid_o !== 1'b1 || fe_warp_id_o !== 3'd1 || fe_pc_o !== 32'h800) begin
      errors++; $display("FAIL mexit_grant got v=%0b id=%0d pc=%0h exp v=1 id=1 pc=800", fe_valid_o, fe_warp_id_o, fe_pc_o);
    end
    cyc();
    fe_ready_i = 1'b0;
    decode(3'd0, 2'd2);
    decode(3'd1, 2'd2);
    ib_all_instr_finished_i = '1;
    cyc();
    checks++; if (warp_done_o !== 1'b1 || warp_done_id_o !== 3'd0 || all_idle_o !== 1'b0) begin
      errors++; $display("FAIL mexit_first got done=%0b id=%0d idle=%0b exp 1 0 0", warp_done_o, warp_done_id_o, all_idle_o);
    end
    cyc();
    checks++; if (warp_done_o !== 1'b1 || warp_done_id_o !== 3'd1 || all_idle_o !== 1'b1) begin
      errors++; $display("FAIL mexit_second got done=%0b id=%0d idle=%0b exp 1 1 1", warp_done_o, warp_done_id_o, all_idle_o);
    end
    cyc();
    checks++; if (warp_done_o !== 1'b0) begin errors++; $display("FAIL mexit_end got done=%0b exp 0", warp_done_o); end
    ib_all_instr_finished_i = '0;
  endtask

  task automatic test_pc_wrap_and_reset();
    do_reset();
    fe_ready_i = 1'b1;
    launch(32'hFFFF_FFFF, 32'h1);
    checks++; if (fe_pc_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_before got pc=%0h exp ffffffff", fe_pc_o); end
    cyc();
    decode(3'd0, 2'd0);
    checks++; if (fe_valid_o !== 1'b1 || fe_pc_o !== 32'h0) begin
      errors++; $display("FAIL wrap_after got v=%0b pc=%0h exp v=1 pc=0", fe_valid_o, fe_pc_o);
    end
    fe_ready_i = 1'b0;
    cyc();
    rst_ni = 1'b0;
    #1;
    checks++; if (all_idle_o !== 1'b1 || fe_valid_o !== 1'b0 || launch_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset got idle=%0b v=%0b lr=%0b exp 1 0 1", all_idle_o, fe_valid_o, launch_ready_o);
    end
    rst_ni = 1'b1;
    cyc();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_fetch();
    test_round_robin();
    test_hold_request();
    test_branch();
    test_exit_reuse();
    test_multi_exit();
    test_pc_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
